// File: rtl/math_adder_pkg.sv
// Shared definitions for the multi-word sequential adder.
//   WORD_W     : width of one datapath word (the per-cycle adder width)
//   WORD_LG    : log2(WORD_W), used to turn a word index into a bit offset
//   state_e    : FSM state encoding (IDLE / ADD / DONE)
//   cnt_width(): word-counter width for a given word count, never below 1 bit
package math_adder_pkg;

  localparam int WORD_W  = 32;
  localparam int WORD_LG = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int nw);
    if (nw > 1) begin
      return $clog2(nw);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/math_adder_brent_kung_032.sv
// 32-bit combinational Brent-Kung parallel-prefix adder.
// Ports:
//   a, b : 32-bit addends
//   ci   : carry into bit 0
//   sum  : 32-bit sum
//   co   : carry out of bit 31
module math_adder_brent_kung_032
  import math_adder_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              ci,
  output logic [WORD_W-1:0] sum,
  output logic              co
);

  logic [WORD_W-1:0] grp_g_s;
  logic [WORD_W-1:0] grp_p_s;
  logic [WORD_W:0]   carry_s;

  // Prefix tree: up-sweep builds power-of-two spans, down-sweep fills the rest,
  // leaving grp_g_s[i]/grp_p_s[i] as generate/propagate of bits [i:0].
  always_comb begin
    logic [WORD_W-1:0] gg_v;
    logic [WORD_W-1:0] pp_v;
    gg_v = a & b;
    pp_v = a ^ b;
    for (int lvl = 0; lvl < WORD_LG; lvl++) begin
      for (int i = (2 << lvl) - 1; i < WORD_W; i += (2 << lvl)) begin
        gg_v[i] = gg_v[i] | (pp_v[i] & gg_v[i - (1 << lvl)]);
        pp_v[i] = pp_v[i] & pp_v[i - (1 << lvl)];
      end
    end
    for (int lvl = WORD_LG - 2; lvl >= 0; lvl--) begin
      for (int i = 3 * (1 << lvl) - 1; i < WORD_W; i += (2 << lvl)) begin
        gg_v[i] = gg_v[i] | (pp_v[i] & gg_v[i - (1 << lvl)]);
        pp_v[i] = pp_v[i] & pp_v[i - (1 << lvl)];
      end
    end
    grp_g_s = gg_v;
    grp_p_s = pp_v;
  end

  // Fold the carry-in into every prefix to get the carry into each bit.
  always_comb begin
    carry_s    = '0;
    carry_s[0] = ci;
    for (int i = 0; i < WORD_W; i++) begin
      carry_s[i+1] = grp_g_s[i] | (grp_p_s[i] & ci);
    end
  end

  assign sum = (a ^ b) ^ carry_s[WORD_W-1:0];
  assign co  = carry_s[WORD_W];

endmodule

// File: rtl/math_adder_multiword_seq.sv
// Sequential multi-word adder: accepts W-bit operands with a valid/ready
// handshake, adds them one 32-bit word per cycle through a single
// Brent-Kung adder (least significant word first), then presents the
// registered sum and carry-out until the consumer takes them.
// Ports:
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_valid / o_ready  : operand handshake (o_ready only in IDLE)
//   i_a, i_b, i_c      : addends and carry-in, captured at acceptance
//   o_valid / i_ready  : result handshake
//   o_sum, o_carry     : registered result, {o_carry,o_sum} = a + b + c
//   o_overflow         : signed overflow flag, present only when
//                        MATH_ADDER_SEQ_OVERFLOW_EN is defined
// Parameter W: operand width, a multiple of 32 and at least 32.
module math_adder_multiword_seq
  import math_adder_pkg::*;
#(
  parameter int W = 128
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_c,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_sum,
  output logic         o_carry
`ifdef MATH_ADDER_SEQ_OVERFLOW_EN
  ,
  output logic         o_overflow
`endif
);

  localparam int NW    = W / WORD_W;
  localparam int CNT_W = cnt_width(NW);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NW - 1);

  state_e              state_r;
  state_e              next_state_s;
  logic [W-1:0]        a_r;
  logic [W-1:0]        b_r;
  logic [W-1:0]        sum_r;
  logic                carry_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [W-1:0]        res_sum_r;
  logic                res_carry_r;
  logic                valid_r;

  logic                ready_s;
  logic                add_en_s;
  logic                accept_s;
  logic                last_word_s;
  logic [CNT_W+WORD_LG-1:0] word_lo_s;
  logic [WORD_W-1:0]   word_a_s;
  logic [WORD_W-1:0]   word_b_s;
  logic [WORD_W-1:0]   word_sum_s;
  logic                word_co_s;
  logic [W-1:0]        sum_next_s;

  assign last_word_s = (cnt_r == LAST_K);
  assign word_lo_s   = {cnt_r, {WORD_LG{1'b0}}};
  assign word_a_s    = a_r[word_lo_s +: WORD_W];
  assign word_b_s    = b_r[word_lo_s +: WORD_W];
  assign accept_s    = ready_s & i_valid;

  math_adder_brent_kung_032 u_word_adder (
    .a   (word_a_s),
    .b   (word_b_s),
    .ci  (carry_r),
    .sum (word_sum_s),
    .co  (word_co_s)
  );

  // Working sum with the current word replaced by this cycle's adder output.
  always_comb begin
    sum_next_s = sum_r;
    sum_next_s[word_lo_s +: WORD_W] = word_sum_s;
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_valid) begin
          next_state_s = ST_ADD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ADD: begin
        if (last_word_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_ADD;
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM output decode; ready is held low while reset is asserted.
  always_comb begin
    ready_s  = 1'b0;
    add_en_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_rst) begin
          ready_s = 1'b0;
        end else begin
          ready_s = 1'b1;
        end
      end
      ST_ADD: begin
        add_en_s = 1'b1;
      end
      ST_DONE: begin
        ready_s  = 1'b0;
        add_en_s = 1'b0;
      end
      default: begin
        ready_s  = 1'b0;
        add_en_s = 1'b0;
      end
    endcase
  end

  // Operand capture and word-serial accumulation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
    end else if (accept_s) begin
      a_r     <= i_a;
      b_r     <= i_b;
      sum_r   <= '0;
      carry_r <= i_c;
      cnt_r   <= '0;
    end else if (add_en_s) begin
      sum_r   <= sum_next_s;
      carry_r <= word_co_s;
      cnt_r   <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r   <= cnt_r;
    end
  end

  // Result registers: only updated on the final word, so an aborted or
  // in-progress operation never shows up on o_sum/o_carry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      res_sum_r   <= '0;
      res_carry_r <= 1'b0;
      valid_r     <= 1'b0;
    end else begin
      if (add_en_s && last_word_s) begin
        res_sum_r   <= sum_next_s;
        res_carry_r <= word_co_s;
      end
      valid_r <= (next_state_s == ST_DONE);
    end
  end

`ifdef MATH_ADDER_SEQ_OVERFLOW_EN
  logic ovf_r;

  // Signed overflow: like-signed operands producing a result of the other sign.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovf_r <= 1'b0;
    end else if (add_en_s && last_word_s) begin
      ovf_r <= (a_r[W-1] == b_r[W-1]) && (sum_next_s[W-1] != a_r[W-1]);
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign o_overflow = ovf_r;
`endif

  assign o_ready = ready_s;
  assign o_valid = valid_r;
  assign o_sum   = res_sum_r;
  assign o_carry = res_carry_r;

endmodule

// File: doc/math_adder_multiword_seq.md
MATH_ADDER_MULTIWORD_SEQ -- requirements
Module: math_adder_multiword_seq

Interface
REQ-001 SHALL have parameter W, default 128, total operand width in bits; legal values are multiples of 32 and at least 32.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port i_valid, input, 1, operand set offered.
REQ-005 SHALL have port o_ready, output, 1, block can accept operands.
REQ-006 SHALL have ports i_a and i_b, input, W, unsigned addends.
REQ-007 SHALL have port i_c, input, 1, carry-in to bit 0.
REQ-008 SHALL have port o_valid, output, 1, result available.
REQ-009 SHALL have port i_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port o_sum, output, W, registered sum.
REQ-011 SHALL have port o_carry, output, 1, registered carry-out of bit W-1.

Function
REQ-012 SHALL define NW = W/32 words; word k occupies bits [32k+31:32k].
REQ-013 SHALL implement a three-state FSM with states IDLE, ADD and DONE.
REQ-014 SHALL drive o_ready=1 only in IDLE.
REQ-015 IDLE: on i_valid&&o_ready SHALL capture i_a, i_b and i_c (carry register), clear the sum register and word counter, and go to ADD; the transition is ignored when i_valid=0.
REQ-016 ADD: each cycle SHALL add word k of A and B plus the carry register through one 32-bit adder, write sum word k, load the carry register with the adder carry-out, and increment k.
REQ-017 Leaving ADD: at k=NW-1 SHALL go to DONE, with o_valid rising exactly NW cycles after the acceptance edge.
REQ-018 DONE: SHALL hold o_valid=1, with o_sum and o_carry stable, until i_ready=1; on that edge SHALL return to IDLE.
REQ-019 i_a, i_b and i_c SHALL be don't-care outside the IDLE handshake; changes during ADD or DONE do not affect the result.
REQ-020 Arithmetic: {o_carry,o_sum} = i_a + i_b + i_c, modulo 2^(W+1); no truncation.
REQ-021 W=32 (NW=1): ADD SHALL last exactly one cycle, and the word counter SHALL have a minimum width of 1 bit.
REQ-022 Throughput SHALL be one operation per NW+2 cycles when i_ready is held at 1.
REQ-023 In DONE with i_valid=1 and i_ready=1 on the same cycle: the result is retired, and the new operands are not accepted until the following IDLE cycle.

Reset
REQ-024 While i_rst=1, the FSM SHALL enter IDLE, o_valid=0, o_sum=0, o_carry=0, the carry register=0 and the word counter=0; o_ready SHALL be 0 during reset and 1 on the first cycle after it.
REQ-025 A reset during ADD or DONE SHALL abort the operation with no o_valid pulse and no partial result visible.

Configuration
REQ-026 With macro MATH_ADDER_SEQ_OVERFLOW_EN defined: SHALL add output o_overflow, 1 bit, registered with o_sum, = (a[W-1]==b[W-1]) && (o_sum[W-1]!=a[W-1]), 0 at reset.
REQ-027 Without the macro: the o_overflow port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Shared package math_adder_pkg SHALL hold the word-width constant (32) and the FSM state enum type.
REQ-029 SHALL instantiate exactly one math_adder_brent_kung_032 as the per-word datapath sub-module; no other adder logic is permitted.

Verification
REQ-030 Carry chain: W=128, a=0x0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1, c=0 -> o_sum=0x0000_0001_0000_0000_0000_0000_0000_0000, o_carry=0, o_valid 4 cycles after acceptance.
REQ-031 Full overflow: a=b=all-ones, c=1 -> o_sum=all-ones, o_carry=1; with the macro, o_overflow=0.
REQ-032 Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_valid, o_sum and o_ready stay 1, stable and 0 respectively; a new i_valid is not accepted until the cycle after i_ready=1.
REQ-033 Reset mid-ADD: assert i_rst for 1 cycle at k=2 -> no o_valid; the next operation a=5, b=7, c=0 yields o_sum=12.
REQ-034 W=32: a=0x8000_0000, b=0x8000_0000, c=0 -> o_sum=0, o_carry=1, o_valid 1 cycle after acceptance; with the macro, o_overflow=1.
REQ-035 Random: 10k random a, b, c with random i_valid and i_ready -> every result equals the reference a+b+c; no result is lost or duplicated.
